// File: rtl/trace_checker.sv
// trace_checker: compares a golden PC/R0..R14 word stream against CPU snapshots taken at retire.
// Optional build macro TRACE_CHECK_HALT_EN freezes checking (HALT state) at the first mismatch.
module trace_checker #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         retire,
  input  logic [31:0]  pc,
  input  logic [479:0] regs,
  input  logic         exp_valid,
  input  logic [31:0]  exp_data,
  output logic         exp_ready,
  output logic [31:0]  record_count,
  output logic [31:0]  match_count,
  output logic         mismatch,
  output logic [31:0]  mm_record,
  output logic [3:0]   mm_field,
  output logic [31:0]  mm_expected,
  output logic [31:0]  mm_actual,
  output logic         overflow,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, CMP, HALT} state_t;

  state_t        state, state_next;
  logic [511:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic [3:0]    field;
  logic          rec_err;
  logic [511:0]  head;
  logic [31:0]   actual;
  logic          full, empty, hs, diff, halt_now, pop, push;

  // Snapshot layout {regs, pc} puts field f at bits [32*f +: 32].
  assign head   = mem[rd_ptr];
  assign actual = head[{field, 5'd0} +: 32];

  assign empty     = (count == '0);
  assign full      = count[AW];
  assign exp_ready = (state == CMP);
  assign busy      = !empty || (state == CMP);
  assign hs        = exp_valid && exp_ready;
  assign diff      = hs && (exp_data != actual);

`ifdef TRACE_CHECK_HALT_EN
  assign halt_now = diff && !mismatch;
`else
  assign halt_now = 1'b0;
`endif

  // A halting mismatch on field 15 leaves the record in the FIFO uncounted.
  assign pop        = hs && (field == 4'd15) && !halt_now;
  assign push       = retire && (!full || pop);
  assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE: if (!empty) state_next = CMP;
      CMP: begin
        if (halt_now)  state_next = HALT;
        else if (pop)  state_next = (count_next != '0) ? CMP : IDLE;
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the snapshot array has no reset; count and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {regs, pc};
  end

  // NOTE: non-blocking assignments keep every register update ordered by the clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      field        <= '0;
      rec_err      <= 1'b0;
      record_count <= '0;
      match_count  <= '0;
      mismatch     <= 1'b0;
      mm_record    <= '0;
      mm_field     <= '0;
      mm_expected  <= '0;
      mm_actual    <= '0;
      overflow     <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (retire && full && !pop) overflow <= 1'b1;

      if (state == IDLE) field <= '0;
      else if (hs)       field <= field + 4'd1;

      if (pop)       rec_err <= 1'b0;
      else if (diff) rec_err <= 1'b1;

      if (pop) begin
        record_count <= record_count + 32'd1;
        if (!(rec_err || diff)) match_count <= match_count + 32'd1;
      end

      if (diff && !mismatch) begin
        mismatch    <= 1'b1;
        mm_record   <= record_count;
        mm_field    <= field;
        mm_expected <= exp_data;
        mm_actual   <= actual;
      end
    end
  end

endmodule
